// File: rtl/regfile_wb.sv
// regfile_wb: 64-bit integer register file with a one-entry write-back buffer.
//
// Sources the ALU operands (rs1_data/rs2_data) and accepts the ALU result as a
// write-back. A write is captured into the buffer on the edge it is presented,
// readable via bypass in the following cycle, and committed to the array on
// the next edge. x0 reads as zero and writes to it are dropped.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rs1_addr/rs1_data   read port 1 (combinational, with bypass)
//   rs2_addr/rs2_data   read port 2 (combinational, with bypass)
//   wb_valid/wb_rd/wb_data  write-back request, destination, value
//   dbg_addr/dbg_data   debug read port (same bypass rules)
//   wb_pending          buffer holds an uncommitted write
//   wr_count            retired (non-x0) write counter, wraps
module regfile_wb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int CNT_W = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
  output logic             wb_pending,
  output logic [CNT_W-1:0] wr_count
);

  // Entry 0 is never written, so it stays at its reset value and is pruned.
  logic [XLEN-1:0]  regs [NREGS];
  logic             buf_valid;
  logic [AW-1:0]    buf_rd;
  logic [XLEN-1:0]  buf_data;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign accept = wb_valid && (wb_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
      cnt_q     <= '0;
    end else begin
      // Commit of the held write and capture of the new one share the edge.
      if (buf_valid) begin
        regs[buf_rd] <= buf_data;
      end
      buf_valid <= accept;
      if (accept) begin
        buf_rd   <= wb_rd;
        buf_data <= wb_data;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Three identical read ports: 0 = rs1, 1 = rs2, 2 = debug.
  logic [AW-1:0]   raddr [3];
  logic [XLEN-1:0] rdata [3];

  assign raddr[0] = rs1_addr;
  assign raddr[1] = rs2_addr;
  assign raddr[2] = dbg_addr;

  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rdata[p] = '0;
      if (raddr[p] != '0) begin
        if (buf_valid && (buf_rd == raddr[p])) begin
          rdata[p] = buf_data;
        end else begin
          rdata[p] = regs[raddr[p]];
        end
      end
    end
  end

  assign rs1_data   = rdata[0];
  assign rs2_data   = rdata[1];
  assign dbg_data   = rdata[2];
  assign wb_pending = buf_valid;
  assign wr_count   = cnt_q;

endmodule

// File: doc/regfile_wb.md
# regfile_wb

64-bit integer register file with a one-entry write-back buffer. It sits on the other side of the datapath ALU: it sources the `rs1_data`/`rs2_data` operands and accepts the ALU `result` as a write-back. Reads are combinational with bypass from the pending write-back, so a write is visible to reads in the cycle after it is presented. The block also keeps a retired-write counter for performance monitoring.

## Interface
- `XLEN`, 64: data width; must match the ALU operand width.
- `NREGS`, 32: number of architectural registers; address width is `$clog2(NREGS)` (5 at default).
- `CNT_W`, 32: width of the retired-write counter.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs1_addr` in 5: read port 1 address.
- `rs2_addr` in 5: read port 2 address.
- `rs1_data` out XLEN: read port 1 data, combinational; feeds the ALU `rs1_data`.
- `rs2_data` out XLEN: read port 2 data, combinational; feeds the ALU `rs2_data`.
- `wb_valid` in 1: write-back request this cycle.
- `wb_rd` in 5: write-back destination register.
- `wb_data` in XLEN: write-back value, normally the ALU `result`.
- `dbg_addr` in 5: debug read address.
- `dbg_data` out XLEN: debug read data, combinational, same bypass rules as the operand ports.
- `wb_pending` out 1: the write-back buffer holds an uncommitted write.
- `wr_count` out CNT_W: number of retired (non-x0) writes.

## Operation
- Storage is the register array `regs[1..NREGS-1]`. x0 is not stored.
- The write-back buffer holds `buf_valid`, `buf_rd` and `buf_data`.
- Write path:
  - Accept rule: on a rising edge with `wb_valid=1` and `wb_rd!=0`, the buffer loads (`buf_valid<=1`, `buf_rd<=wb_rd`, `buf_data<=wb_data`).
  - x0 rule: `wb_valid=1` with `wb_rd=0` is dropped. The buffer clears if it is not reloaded, and the counter does not change.
  - Commit rule: on every rising edge with `buf_valid=1`, `regs[buf_rd]<=buf_data`. This happens in parallel with the buffer accepting a new write.
  - Empty rule: if `wb_valid=0`, or the write is dropped, the buffer sets `buf_valid<=0`.
- Read path (applies to each of `rs1`, `rs2`, `dbg`):
  - Address 0 returns 0.
  - Otherwise, if `buf_valid` and `buf_rd==addr`, return `buf_data` (bypass).
  - Otherwise return `regs[addr]`.
- Counter: `wr_count` increments by 1 on each accepted write. It wraps modulo 2^CNT_W (0xFFFFFFFF → 0).
- `wb_pending` is `buf_valid`.
- No backpressure: one write is accepted per cycle, always.

## Timing
- Reset values while `rst_n=0` (asynchronous): all `regs`=0, `buf_valid`=0, `buf_rd`=0, `buf_data`=0, `wr_count`=0. Therefore `rs1_data`/`rs2_data`/`dbg_data`=0 for every address and `wb_pending`=0.
- Reset asserted mid-operation:
  - A pending buffered write is discarded and never committed.
  - The array clears immediately, not at the next edge.
- Write-to-read latency: a write presented in cycle N (captured at edge N) is readable via bypass in cycle N+1 and from the array from cycle N+2 on. There is no same-cycle read of `wb_data`.
- Back-to-back writes to the same rd in cycles N and N+1:
  - At edge N+1 the old value commits and the buffer takes the new value.
  - Reads in N+2 return the new value.
  - Edge N+2 commits the new value.
- Back-to-back writes to different rd: each commits one cycle after capture. Both are readable continuously from their respective N+1.
- Read of an address that matches neither the buffer nor x0 returns the array value with zero added latency. Both read ports and the debug port may address the same register simultaneously.
- First edge after `rst_n` deasserts behaves as a normal edge. No deassertion synchronizer is in this block.

## Test plan
- Reset: drive `rst_n=0` mid-run with `buf_valid=1` → immediately all reads return 0, `wb_pending=0`, `wr_count=0`. After release, the discarded register still reads 0.
- Basic write/read: write x5=0x1234_5678_9ABC_DEF0 in cycle 1.
  - Cycle 2: `rs1_addr=5` returns it via bypass with `wb_pending=1`.
  - Cycle 3: it returns from the array with `wb_pending=0`; `wr_count=1`.
- x0: write x0=0xFFFF…FF → `rs1_data`/`rs2_data` at address 0 stay 0, `wb_pending=0`, `wr_count` unchanged.
- Same-rd back-to-back: x7=0xA then x7=0xB in consecutive cycles → cycle after first reads 0xA, cycle after second reads 0xB, final array x7=0xB, `wr_count=2`.
- Dual-port plus debug: fill x1..x31 with value `i*0x0101`, then read all pairs `(rs1=i, rs2=31-i, dbg=i)` → each returns the stored pattern with no cross-talk.
- Counter wrap: force `wr_count` to 0xFFFF_FFFF, then one accepted write → `wr_count=0`, and the register write completes normally.
